dft_capture_buffer: RTL and testbench
=====================================

Name: dft_capture_buffer

Overview:
- Parametrised per-scan-chain unload buffer placed between the DFT scan-chain outputs and the AXI-side register interface of the prewrapper.
- Each chain's strobed 32-bit unload words are pushed into that chain's FIFO. The host drains the FIFO by reading a per-channel DATA register.
- The scan-chain commit is acknowledged only after that channel's FIFO is empty, which gives lossless back-pressure that the single-register prewrapper datapath lacks.

Parameters:
- P_SC_NBR, 16, number of scan-chain channels (1..16).
- P_DEPTH, 8, FIFO entries per channel (power of 2, 2..256).
- P_DATA_W, 32, unload word width (fixed at 32 for the AXI map).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- axi_rd_addr  in  32  register read word address; bits [7:0] decoded, upper bits ignored.
- axi_rd_en  in  1  read strobe, one access per cycle.
- axi_rd_msg  out  32  read data, registered.
- axi_wr_addr  in  32  register write word address; bits [7:0] decoded.
- axi_wr_en  in  1  write strobe.
- axi_wr_msg  in  32  write data.
- dft_output_data  in  32*P_SC_NBR  unload words; channel i uses bits [32i+31:32i].
- dft_output_strobe  in  P_SC_NBR  word valid, one push per high cycle.
- dft_op_commit  in  P_SC_NBR  chain finished unloading; level, held until acked.
- dft_commit_ack  out  P_SC_NBR  commit acknowledge.
- irq_done  out  1  OR of all channels in state ACK.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every FIFO is empty and every flag is cleared.
  - Every channel FSM is in IDLE.
  - CTRL=0.
  - axi_rd_msg=0, dft_commit_ack=0, irq_done=0.
- Register map (word addresses):
  - 0x00 CTRL, R/W. Bit0 ENABLE. Bit1 SOFT_CLR: write-1, self-clearing, always reads 0.
  - 0x01 DONE, RO. Bit i = channel i in state ACK.
  - 0x02 OVF, RO. Bit i = overflow sticky of channel i.
  - Per-channel block at 0x10+4i:
    - +0 DATA, RO. Read pops the FIFO head.
    - +1 COUNT, RO. Occupancy 0..P_DEPTH.
    - +2 FLAGS, RO. Bit0 overflow, bit1 underflow, bits[5:4] FSM state.
    - +3 FLAGCLR, W1C. Bit0 clears overflow, bit1 clears underflow.
  - Unmapped addresses and channels >= P_SC_NBR read 0; writes to them are ignored.
- Read latency:
  - axi_rd_msg is valid the cycle after axi_rd_en and holds until the next read.
  - A DATA read returns the pre-pop head word; the pop takes effect at the same edge.
- Channel FSM (2-bit encoding: IDLE=0, CAPT=1, DRAIN=2, ACK=3):
  - IDLE -> CAPT when ENABLE=1.
  - CAPT -> DRAIN when dft_op_commit[i]=1.
  - DRAIN -> ACK when COUNT=0. This is evaluated after the same-cycle pop, so a final pop reaches ACK one cycle later.
  - ACK: dft_commit_ack[i]=1 (registered). ACK -> IDLE when dft_op_commit[i]=0; ack drops the same edge.
  - CAPT -> IDLE when ENABLE=0, with FIFO contents retained.
- Push rules:
  - A strobe pushes only in CAPT, including the commit cycle itself.
  - Strobes in IDLE, DRAIN and ACK are ignored.
  - Push while full with no same-cycle pop: word dropped, overflow sticky set, COUNT stays P_DEPTH.
  - Push while full with a same-cycle pop: push accepted, no overflow.
  - Simultaneous push and pop: COUNT unchanged.
- Underflow: a DATA read while empty returns 0, sets the underflow sticky and does not change the pointers.
- Pointers: log2(P_DEPTH) bits plus a wrap bit. COUNT = wr_ptr - rd_ptr (modulo, including the wrap bit).
- SOFT_CLR: at the next edge every FIFO is flushed, flags are cleared, every FSM returns to IDLE and acks drop. ENABLE keeps its written value, so channels re-enter CAPT one cycle later if ENABLE=1. A strobe in the clear cycle is discarded.
- Reset mid-operation: the asynchronous clear overrides everything, and dft_commit_ack drops immediately.
- Simultaneous write to CTRL and read: both are serviced.

Decomposition:
- Package dft_capture_pkg:
  - Register offsets: CTRL, DONE, OVF, CH_BASE=0x10, CH_STRIDE=4.
  - Field offsets within the channel block: DATA, COUNT, FLAGS, FLAGCLR.
  - FSM state encoding.
  - Flag bit positions.
- Sub-module dft_capture_channel: one FIFO plus one FSM plus its flags, generated P_SC_NBR times.
- The top level holds the address decode, CTRL, the read mux/register and irq_done.

Test Plan:
- Basic capture:
  - Stimulus: ENABLE=1; ch0 pushes 0xA0..0xA2; ch0 commit held high; host reads 0x10 three times.
  - Response: reads 0xA0, 0xA1, 0xA2; DONE[0]=1 after the last pop; ack high until commit drops, then ack=0 and state=CAPT.
- Overflow:
  - Stimulus: P_DEPTH=8, 9 strobes on ch3, no reads.
  - Response: COUNT(0x1D)=8, OVF bit3=1, reads return the first 8 words; FLAGCLR 0x1F write 1 clears it.
- Full boundary:
  - Stimulus: FIFO full, strobe and DATA pop in the same cycle.
  - Response: COUNT stays 8, no overflow, the new word is delivered last.
- Underflow and decode:
  - Stimulus: read 0x14 on empty ch1; read 0xF0.
  - Response: 0x00; ch1 FLAGS bit1=1; 0xF0 returns 0 with no side effects.
- Wrap-around:
  - Stimulus: 20 interleaved push/pop pairs on ch2 with data = index.
  - Response: in-order data 0..19, COUNT never exceeds 1.
- Reset and clear mid-operation:
  - Stimulus: ch5 in ACK; SOFT_CLR, then later reset low for 1 cycle while in DRAIN.
  - Response: ack drops the next edge after SOFT_CLR and immediately on reset; COUNT=0; FLAGS state reads IDLE or CAPT per ENABLE.

Source files
------------

// File: rtl/dft_capture_pkg.sv
// Shared register map, field offsets, flag positions and channel FSM encoding
// for the DFT scan-chain unload buffer.
package dft_capture_pkg;

  localparam logic [7:0]  REG_CTRL  = 8'h00;
  localparam logic [7:0]  REG_DONE  = 8'h01;
  localparam logic [7:0]  REG_OVF   = 8'h02;
  localparam logic [7:0]  CH_BASE   = 8'h10;
  localparam int unsigned CH_STRIDE = 4;

  localparam logic [1:0] FLD_DATA    = 2'd0;
  localparam logic [1:0] FLD_COUNT   = 2'd1;
  localparam logic [1:0] FLD_FLAGS   = 2'd2;
  localparam logic [1:0] FLD_FLAGCLR = 2'd3;

  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_SOFT_CLR  = 1;
  localparam int unsigned FLAG_OVF       = 0;
  localparam int unsigned FLAG_UDF       = 1;
  localparam int unsigned FLAG_STATE_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic       hit;
    logic [5:0] ch;
    logic [1:0] fld;
  } ch_addr_t;

  // The channel block stride is 4 words, so the field is the low two bits of
  // the offset from CH_BASE and the channel index is the rest.
  function automatic ch_addr_t decode_ch(input logic [7:0] addr, input int unsigned n_ch);
    ch_addr_t   d;
    logic [7:0] off;
    off   = addr - CH_BASE;
    d.ch  = off[7:2];
    d.fld = off[1:0];
    d.hit = (addr >= CH_BASE) && (32'(off[7:2]) < n_ch);
    return d;
  endfunction

endpackage

// File: rtl/dft_capture_channel.sv
// One scan-chain unload channel: FIFO with wrap-bit pointers, sticky
// overflow/underflow flags and the capture/drain/ack handshake FSM.
module dft_capture_channel
  import dft_capture_pkg::*;
#(
  parameter int unsigned P_DEPTH  = 8,
  parameter int unsigned P_DATA_W = 32,
  localparam int unsigned AW      = $clog2(P_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                soft_clr,
  input  logic [P_DATA_W-1:0] push_data,
  input  logic                strobe,
  input  logic                commit,
  input  logic                pop,
  input  logic                clr_ovf,
  input  logic                clr_udf,
  output logic [P_DATA_W-1:0] head_data,
  output logic [AW:0]         count,
  output logic                ovf,
  output logic                udf,
  output logic                ack,
  output ch_state_e           state
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(P_DEPTH);

  logic [P_DATA_W-1:0] mem [P_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  ch_state_e           state_nxt;
  logic                empty;
  logic                full;
  logic                push_req;
  logic                pop_ok;
  logic                push_ok;
  logic                ovf_set;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign push_req  = strobe && (state == ST_CAPT) && !soft_clr;
  assign pop_ok    = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted.
  assign push_ok   = push_req && (!full || pop_ok);
  assign ovf_set   = push_req && full && !pop_ok;
  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (soft_clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (pop && empty) udf <= 1'b1;
      else if (clr_udf) udf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // DRAIN looks at the registered count, so the last pop reaches ACK one
  // cycle after the pop edge.
  always_comb begin
    state_nxt = state;
    if (soft_clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (enable) state_nxt = ST_CAPT;
        ST_CAPT: begin
          if (commit)       state_nxt = ST_DRAIN;
          else if (!enable) state_nxt = ST_IDLE;
        end
        ST_DRAIN: if (empty)   state_nxt = ST_ACK;
        ST_ACK:   if (!commit) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ack = (state == ST_ACK);
  end

endmodule

// File: rtl/dft_capture_buffer.sv
// Per-scan-chain unload buffer: register decode, CTRL, registered read mux
// and the array of capture channels.
module dft_capture_buffer
  import dft_capture_pkg::*;
#(
  parameter int unsigned P_SC_NBR = 16,
  parameter int unsigned P_DEPTH  = 8,
  parameter int unsigned P_DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  axi_rd_addr,
  input  logic                         axi_rd_en,
  output logic [31:0]                  axi_rd_msg,
  input  logic [31:0]                  axi_wr_addr,
  input  logic                         axi_wr_en,
  input  logic [31:0]                  axi_wr_msg,
  input  logic [P_DATA_W*P_SC_NBR-1:0] dft_output_data,
  input  logic [P_SC_NBR-1:0]          dft_output_strobe,
  input  logic [P_SC_NBR-1:0]          dft_op_commit,
  output logic [P_SC_NBR-1:0]          dft_commit_ack,
  output logic                         irq_done
);

  localparam int unsigned AW = $clog2(P_DEPTH);

  logic                ctrl_enable;
  logic                wr_ctrl;
  logic                soft_clr;
  ch_addr_t            rd_dec;
  ch_addr_t            wr_dec;
  logic [31:0]         rd_word;
  logic [P_DATA_W-1:0] ch_head  [P_SC_NBR];
  logic [AW:0]         ch_count [P_SC_NBR];
  ch_state_e           ch_state [P_SC_NBR];
  logic [P_SC_NBR-1:0] ch_ovf;
  logic [P_SC_NBR-1:0] ch_udf;
  logic                unused_bits;

  assign unused_bits = ^{axi_rd_addr[31:8], axi_wr_addr[31:8], axi_wr_msg[31:2]};

  assign rd_dec   = decode_ch(axi_rd_addr[7:0], P_SC_NBR);
  assign wr_dec   = decode_ch(axi_wr_addr[7:0], P_SC_NBR);
  assign wr_ctrl  = axi_wr_en && (axi_wr_addr[7:0] == REG_CTRL);
  assign soft_clr = wr_ctrl && axi_wr_msg[CTRL_SOFT_CLR];
  assign irq_done = |dft_commit_ack;

  // SOFT_CLR is a one-cycle strobe; only ENABLE is stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ctrl_enable <= 1'b0;
    else if (wr_ctrl) ctrl_enable <= axi_wr_msg[CTRL_ENABLE];
  end

  for (genvar g = 0; g < P_SC_NBR; g++) begin : g_ch
    logic ch_wr_sel;
    assign ch_wr_sel = axi_wr_en && wr_dec.hit && (wr_dec.ch == 6'(g)) && (wr_dec.fld == FLD_FLAGCLR);

    dft_capture_channel #(
      .P_DEPTH  (P_DEPTH),
      .P_DATA_W (P_DATA_W)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .enable    (ctrl_enable),
      .soft_clr  (soft_clr),
      .push_data (dft_output_data[g*P_DATA_W +: P_DATA_W]),
      .strobe    (dft_output_strobe[g]),
      .commit    (dft_op_commit[g]),
      .pop       (axi_rd_en && rd_dec.hit && (rd_dec.ch == 6'(g)) && (rd_dec.fld == FLD_DATA)),
      .clr_ovf   (ch_wr_sel && axi_wr_msg[FLAG_OVF]),
      .clr_udf   (ch_wr_sel && axi_wr_msg[FLAG_UDF]),
      .head_data (ch_head[g]),
      .count     (ch_count[g]),
      .ovf       (ch_ovf[g]),
      .udf       (ch_udf[g]),
      .ack       (dft_commit_ack[g]),
      .state     (ch_state[g])
    );
  end

  always_comb begin
    rd_word = '0;
    if (rd_dec.hit) begin
      for (int i = 0; i < P_SC_NBR; i++) begin
        if (rd_dec.ch == 6'(i)) begin
          case (rd_dec.fld)
            FLD_DATA:  rd_word = 32'(ch_head[i]);
            FLD_COUNT: rd_word = 32'(ch_count[i]);
            FLD_FLAGS: begin
              rd_word[FLAG_OVF]              = ch_ovf[i];
              rd_word[FLAG_UDF]              = ch_udf[i];
              rd_word[FLAG_STATE_LSB +: 2]   = ch_state[i];
            end
            default:   rd_word = '0;
          endcase
        end
      end
    end else begin
      case (axi_rd_addr[7:0])
        REG_CTRL: rd_word[CTRL_ENABLE] = ctrl_enable;
        REG_DONE: rd_word = 32'(dft_commit_ack);
        REG_OVF:  rd_word = 32'(ch_ovf);
        default:  rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         axi_rd_msg <= '0;
    else if (axi_rd_en) axi_rd_msg <= rd_word;
  end

endmodule

// File: tb/tb_dft_capture_buffer.sv
// Directed self-checking bench for dft_capture_buffer: capture/drain/ack,
// overflow, full boundary, underflow/decode, wrap-around, clear and reset.
module tb_dft_capture_buffer;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   axi_rd_addr;
  logic          axi_rd_en;
  logic [31:0]   axi_rd_msg;
  logic [31:0]   axi_wr_addr;
  logic          axi_wr_en;
  logic [31:0]   axi_wr_msg;
  logic [511:0]  dft_output_data;
  logic [15:0]   dft_output_strobe;
  logic [15:0]   dft_op_commit;
  logic [15:0]   dft_commit_ack;
  logic          irq_done;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   rd_val;

  dft_capture_buffer #(.P_SC_NBR(16), .P_DEPTH(8), .P_DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .axi_rd_addr       (axi_rd_addr),
    .axi_rd_en         (axi_rd_en),
    .axi_rd_msg        (axi_rd_msg),
    .axi_wr_addr       (axi_wr_addr),
    .axi_wr_en         (axi_wr_en),
    .axi_wr_msg        (axi_wr_msg),
    .dft_output_data   (dft_output_data),
    .dft_output_strobe (dft_output_strobe),
    .dft_op_commit     (dft_op_commit),
    .dft_commit_ack    (dft_commit_ack),
    .irq_done          (irq_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
    axi_rd_addr = 32'(a);
    axi_rd_en   = 1'b1;
    tick();
    axi_rd_en   = 1'b0;
    d           = axi_rd_msg;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    axi_wr_addr = 32'(a);
    axi_wr_msg  = d;
    axi_wr_en   = 1'b1;
    tick();
    axi_wr_en   = 1'b0;
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    dft_output_data[ch*32 +: 32] = d;
    dft_output_strobe[ch]        = 1'b1;
    tick();
    dft_output_strobe[ch]        = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    axi_rd_addr = '0; axi_rd_en = 1'b0;
    axi_wr_addr = '0; axi_wr_en = 1'b0; axi_wr_msg = '0;
    dft_output_data = '0; dft_output_strobe = '0; dft_op_commit = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_msg", axi_rd_msg, 32'h0);
    check("rst_ack", 32'(dft_commit_ack), 32'h0);
    check("rst_irq", 32'(irq_done), 32'h0);
    reset = 1'b1;
    tick();
    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_done", 8'h01, 32'h0);
    rd_chk("rst_ch0_flags", 8'h12, 32'h0);

    // Basic capture on ch0
    reg_wr(8'h00, 32'h1);
    tick();
    rd_chk("ch0_capt", 8'h12, 32'h10);
    push(0, 32'hA0);
    push(0, 32'hA1);
    push(0, 32'hA2);
    rd_chk("ch0_count3", 8'h11, 32'd3);
    dft_op_commit[0] = 1'b1;
    tick();
    push(0, 32'hBB);
    rd_chk("ch0_pop0", 8'h10, 32'hA0);
    rd_chk("ch0_pop1", 8'h10, 32'hA1);
    rd_chk("ch0_pop2", 8'h10, 32'hA2);
    check("ch0_ack_late", 32'(dft_commit_ack), 32'h0);
    tick();
    check("ch0_ack", 32'(dft_commit_ack), 32'h0001);
    check("ch0_irq", 32'(irq_done), 32'h1);
    rd_chk("ch0_done", 8'h01, 32'h1);
    rd_chk("ch0_flags_ack", 8'h12, 32'h30);
    dft_op_commit[0] = 1'b0;
    tick();
    check("ch0_ack_drop", 32'(dft_commit_ack), 32'h0);
    tick();
    rd_chk("ch0_recapt", 8'h12, 32'h10);

    // Underflow and decode on ch1
    rd_chk("ch1_udf_data", 8'h14, 32'h0);
    rd_chk("ch1_udf_flags", 8'h16, 32'h12);
    rd_chk("ch1_count", 8'h15, 32'h0);
    rd_chk("ch0_count_nz", 8'h11, 32'h0);
    rd_chk("unmapped_f0", 8'hF0, 32'h0);
    rd_chk("ch1_flags_keep", 8'h16, 32'h12);
    reg_wr(8'h17, 32'h2);
    rd_chk("ch1_udf_clr", 8'h16, 32'h10);

    // Overflow on ch3
    for (int k = 0; k < 9; k++) push(3, 32'h300 + 32'(k));
    rd_chk("ch3_count_full", 8'h1D, 32'd8);
    rd_chk("ovf_reg", 8'h02, 32'h8);
    rd_chk("ch3_flags_ovf", 8'h1E, 32'h11);
    for (int k = 0; k < 8; k++) rd_chk("ch3_ovf_data", 8'h1C, 32'h300 + 32'(k));
    rd_chk("ch3_count_empty", 8'h1D, 32'd0);
    reg_wr(8'h1F, 32'h1);
    rd_chk("ovf_reg_clr", 8'h02, 32'h0);
    rd_chk("ch3_flags_clr", 8'h1E, 32'h10);

    // Full boundary: push and pop together while full
    for (int k = 0; k < 8; k++) push(3, 32'h400 + 32'(k));
    rd_chk("ch3_full", 8'h1D, 32'd8);
    dft_output_data[3*32 +: 32] = 32'h408;
    dft_output_strobe[3] = 1'b1;
    axi_rd_addr = 32'h1C;
    axi_rd_en = 1'b1;
    tick();
    dft_output_strobe[3] = 1'b0;
    axi_rd_en = 1'b0;
    check("ch3_fullpp_data", axi_rd_msg, 32'h400);
    rd_chk("ch3_fullpp_count", 8'h1D, 32'd8);
    rd_chk("ch3_fullpp_ovf", 8'h02, 32'h0);
    for (int k = 1; k < 9; k++) rd_chk("ch3_fullpp_drain", 8'h1C, 32'h400 + 32'(k));

    // Wrap-around on ch2
    for (int k = 0; k < 20; k++) begin
      push(2, 32'(k));
      exp_q.push_back(32'(k));
      rd_chk("ch2_wrap_count", 8'h19, 32'd1);
      reg_rd(8'h18, rd_val);
      check("ch2_wrap_data", rd_val, exp_q.pop_front());
    end
    rd_chk("ch2_wrap_end", 8'h19, 32'd0);

    // ch5 into ACK, ch6 and ch1 carrying state to be cleared
    push(5, 32'h55);
    dft_op_commit[5] = 1'b1;
    tick();
    rd_chk("ch5_pop", 8'h24, 32'h55);
    tick();
    check("ch5_ack", 32'(dft_commit_ack), 32'h0020);
    push(6, 32'h61);
    push(6, 32'h62);
    rd_chk("ch1_udf_again", 8'h14, 32'h0);

    // SOFT_CLR with a strobe in the same cycle
    dft_output_data[6*32 +: 32] = 32'h99;
    dft_output_strobe[6] = 1'b1;
    reg_wr(8'h00, 32'h3);
    dft_output_strobe[6] = 1'b0;
    check("clr_ack_drop", 32'(dft_commit_ack), 32'h0);
    check("clr_irq_drop", 32'(irq_done), 32'h0);
    rd_chk("clr_ch5_idle", 8'h26, 32'h00);
    rd_chk("clr_ch5_capt", 8'h26, 32'h10);
    rd_chk("clr_ch5_count", 8'h25, 32'h0);
    rd_chk("clr_ch6_count", 8'h29, 32'h0);
    rd_chk("clr_ch1_flags", 8'h16, 32'h10);
    rd_chk("clr_ctrl", 8'h00, 32'h1);

    // Reset asserted while ch6 drains and ch5 acks
    push(6, 32'h66);
    dft_op_commit[6] = 1'b1;
    tick();
    rd_chk("ch6_drain", 8'h2A, 32'h20);
    check("ch5_ack_again", 32'(dft_commit_ack), 32'h0020);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ack", 32'(dft_commit_ack), 32'h0);
    check("rst_mid_irq", 32'(irq_done), 32'h0);
    check("rst_mid_rd_msg", axi_rd_msg, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    dft_op_commit = '0;
    tick();
    rd_chk("rst_ch6_count", 8'h29, 32'h0);
    rd_chk("rst_ch6_flags", 8'h2A, 32'h0);
    rd_chk("rst_ctrl_after", 8'h00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
